dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the data memory port between the CPU memory stage and an external
// (DMA/peripheral) requester. The CPU has priority, and a starvation counter bounds the external wait.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd_en,
  input  logic              cpu_wrt_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wrt_data,
  input  logic [1:0]        cpu_width,
  input  logic              cpu_unsigned,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_wdata,
  input  logic [1:0]        ext_width,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [31:0]       ext_rdata,
  output logic              ext_err,
  output logic              mem_rd_en,
  output logic              mem_wrt_en,
  output logic              mem_unsigned,
  output logic [1:0]        mem_width,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wrt_data,
  input  logic [31:0]       mem_rd_data,
  input  logic              mem_error
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {CPU_OWN, EXT_OWN, EXT_RESP} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    starve_cnt;
  logic                hold_we;
  logic [ADDR_W-1:0]   hold_addr;
  logic [31:0]         hold_wdata;
  logic [1:0]          hold_width;
  logic                cpu_access;
  logic                starve_hit;
  logic                grant;

  assign cpu_access = cpu_rd_en | cpu_wrt_en;
  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));
  // No grant while in reset: the captured fields would be cleared anyway.
  assign grant      = rst_n && (state == CPU_OWN) && ext_req && (!cpu_access || starve_hit);

  // Next state, memory port mux and stall/grant strobes.
  always_comb begin
    state_nxt    = state;
    ext_gnt      = 1'b0;
    cpu_stall    = 1'b0;
    mem_rd_en    = 1'b0;
    mem_wrt_en   = 1'b0;
    mem_unsigned = 1'b0;
    mem_width    = 2'b00;
    mem_addr     = '0;
    mem_wrt_data = 32'h0;
    case (state)
      CPU_OWN: begin
        mem_rd_en    = cpu_rd_en;
        mem_wrt_en   = cpu_wrt_en;
        mem_unsigned = cpu_unsigned;
        mem_width    = cpu_width;
        mem_addr     = cpu_addr;
        mem_wrt_data = cpu_wrt_data;
        ext_gnt      = grant;
        if (grant) state_nxt = EXT_OWN;
      end
      EXT_OWN: begin
        // Enables dropped under reset so an abandoned transfer never touches memory.
        mem_rd_en    = rst_n & ~hold_we;
        mem_wrt_en   = rst_n & hold_we;
        mem_unsigned = 1'b1;
        mem_width    = hold_width;
        mem_addr     = hold_addr;
        mem_wrt_data = hold_wdata;
        cpu_stall    = cpu_access;
        state_nxt    = hold_we ? CPU_OWN : EXT_RESP;
      end
      EXT_RESP: begin
        cpu_stall = cpu_access;
        state_nxt = CPU_OWN;
      end
      default: state_nxt = CPU_OWN;
    endcase
  end

  // State, starvation counter, holding registers and read response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CPU_OWN;
      starve_cnt <= '0;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= 32'h0;
      hold_width <= 2'b00;
      ext_rvalid <= 1'b0;
      ext_rdata  <= 32'h0;
      ext_err    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (grant || !ext_req)
        starve_cnt <= '0;
      else if ((state == CPU_OWN) && cpu_access && !starve_hit)
        starve_cnt <= starve_cnt + CNT_W'(1);

      if (grant) begin
        hold_we    <= ext_we;
        hold_addr  <= ext_addr;
        hold_wdata <= ext_wdata;
        hold_width <= ext_width;
      end

      // Read data is sampled while the external read drives memory, presented in EXT_RESP.
      ext_rvalid <= (state == EXT_OWN) && !hold_we;
      if ((state == EXT_OWN) && !hold_we) begin
        ext_rdata <= mem_rd_data;
        ext_err   <= mem_error;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small combinational-read data memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_rd_en, cpu_wrt_en, cpu_unsigned;
  logic [31:0] cpu_addr, cpu_wrt_data;
  logic [1:0]  cpu_width;
  logic        cpu_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic [1:0]  ext_width;
  logic        ext_gnt, ext_rvalid, ext_err;
  logic [31:0] ext_rdata;
  logic        mem_rd_en, mem_wrt_en, mem_unsigned;
  logic [1:0]  mem_width;
  logic [31:0] mem_addr, mem_wrt_data, mem_rd_data;
  logic        mem_error;

  logic [31:0] mem [0:255];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd_en(cpu_rd_en), .cpu_wrt_en(cpu_wrt_en), .cpu_addr(cpu_addr),
    .cpu_wrt_data(cpu_wrt_data), .cpu_width(cpu_width), .cpu_unsigned(cpu_unsigned),
    .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_width(ext_width), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
    .ext_rdata(ext_rdata), .ext_err(ext_err),
    .mem_rd_en(mem_rd_en), .mem_wrt_en(mem_wrt_en), .mem_unsigned(mem_unsigned),
    .mem_width(mem_width), .mem_addr(mem_addr), .mem_wrt_data(mem_wrt_data),
    .mem_rd_data(mem_rd_data), .mem_error(mem_error)
  );

  // Word memory: combinational read, misalignment flagged, word writes on the clock.
  assign mem_rd_data = mem[mem_addr[9:2]];
  assign mem_error   = ((mem_width == 2'b10) && (mem_addr[1:0] != 2'b00)) ||
                       ((mem_width == 2'b01) && mem_addr[0]);
  always @(posedge clk)
    if (mem_wrt_en && !mem_error) mem[mem_addr[9:2]] <= mem_wrt_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cpu_set(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    cpu_rd_en = rd; cpu_wrt_en = wr; cpu_addr = a; cpu_wrt_data = d;
    cpu_width = 2'b10; cpu_unsigned = 1'b0;
  endtask

  task automatic ext_set(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d; ext_width = 2'b10;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst_n = 1'b0;
    cpu_set(0, 0, 32'h0, 32'h0);
    ext_set(0, 0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt",    32'(ext_gnt),    32'h0);
    chk("rst_rvalid", 32'(ext_rvalid), 32'h0);
    chk("rst_err",    32'(ext_err),    32'h0);
    chk("rst_rdata",  ext_rdata,       32'h0);
    chk("rst_stall",  32'(cpu_stall),  32'h0);
    rst_n = 1'b1;

    // Idle CPU, external write.
    @(negedge clk); ext_set(1, 1, 32'h40, 32'hDEADBEEF); #1;
    chk("w_gnt",   32'(ext_gnt),   32'h1);
    chk("w_stall", 32'(cpu_stall), 32'h0);
    @(negedge clk); ext_set(0, 0, 32'h80, 32'h11111111); #1;
    chk("w_mwe",   32'(mem_wrt_en),   32'h1);
    chk("w_maddr", mem_addr,          32'h40);
    chk("w_mdata", mem_wrt_data,      32'hDEADBEEF);
    chk("w_munsg", 32'(mem_unsigned), 32'h1);
    chk("w_stall2", 32'(cpu_stall),   32'h0);
    @(negedge clk); #1;
    chk("w_done",  32'(mem_wrt_en), 32'h0);
    chk("w_norv",  32'(ext_rvalid), 32'h0);

    // External read of the word just written.
    @(negedge clk); ext_set(1, 0, 32'h40, 32'h0); #1;
    chk("r_gnt", 32'(ext_gnt), 32'h1);
    @(negedge clk); ext_set(0, 0, 32'h0, 32'h0); #1;
    chk("r_mre",   32'(mem_rd_en),  32'h1);
    chk("r_maddr", mem_addr,        32'h40);
    chk("r_rv0",   32'(ext_rvalid), 32'h0);
    @(negedge clk); #1;
    chk("r_rv1",   32'(ext_rvalid), 32'h1);
    chk("r_rdata", ext_rdata,       32'hDEADBEEF);
    chk("r_err",   32'(ext_err),    32'h0);
    chk("r_mre0",  32'(mem_rd_en),  32'h0);
    @(negedge clk); #1;
    chk("r_rv2",   32'(ext_rvalid), 32'h0);

    // CPU write and external write collide with an empty starvation count.
    @(negedge clk); cpu_set(0, 1, 32'h44, 32'h12345678); ext_set(1, 1, 32'h48, 32'hA5A5A5A5); #1;
    chk("p_gnt",   32'(ext_gnt),    32'h0);
    chk("p_mwe",   32'(mem_wrt_en), 32'h1);
    chk("p_maddr", mem_addr,        32'h44);
    chk("p_mdata", mem_wrt_data,    32'h12345678);
    @(negedge clk); cpu_set(0, 0, 32'h0, 32'h0); #1;
    chk("p_gnt2",  32'(ext_gnt), 32'h1);
    @(negedge clk); ext_set(0, 0, 32'h0, 32'h0); #1;
    chk("p_maddr2", mem_addr,     32'h48);
    chk("p_mdata2", mem_wrt_data, 32'hA5A5A5A5);
    @(negedge clk); #1;

    // Starvation, external read: grant on the 5th cycle, then 2 stall cycles.
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); cpu_set(1, 0, 32'h44, 32'h0); ext_set(1, 0, 32'h48, 32'h0); #1;
      chk("sr_gnt",   32'(ext_gnt),   (i == 5) ? 32'h1 : 32'h0);
      chk("sr_stall", 32'(cpu_stall), 32'h0);
      chk("sr_maddr", mem_addr,       32'h44);
    end
    @(negedge clk); ext_set(0, 0, 32'h0, 32'h0); #1;
    chk("sr_stall1", 32'(cpu_stall), 32'h1);
    chk("sr_maddr2", mem_addr,       32'h48);
    @(negedge clk); #1;
    chk("sr_stall2", 32'(cpu_stall), 32'h1);
    chk("sr_rv",     32'(ext_rvalid), 32'h1);
    chk("sr_rdata",  ext_rdata,       32'hA5A5A5A5);
    @(negedge clk); #1;
    chk("sr_stall3", 32'(cpu_stall),  32'h0);
    chk("sr_cpu",    mem_addr,        32'h44);
    chk("sr_cpudat", mem_rd_data,     32'h12345678);

    // Starvation, external write: 1 stall cycle.
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); ext_set(1, 1, 32'h50, 32'h0BADF00D); #1;
      chk("sw_gnt", 32'(ext_gnt), (i == 5) ? 32'h1 : 32'h0);
    end
    @(negedge clk); ext_set(0, 0, 32'h0, 32'h0); #1;
    chk("sw_stall1", 32'(cpu_stall),  32'h1);
    chk("sw_mwe",    32'(mem_wrt_en), 32'h1);
    @(negedge clk); #1;
    chk("sw_stall2", 32'(cpu_stall), 32'h0);
    chk("sw_mre",    32'(mem_rd_en), 32'h1);
    cpu_set(0, 0, 32'h0, 32'h0);

    // Misaligned external word read reports an error with the response.
    @(negedge clk); ext_set(1, 0, 32'h42, 32'h0); #1;
    chk("e_gnt", 32'(ext_gnt), 32'h1);
    @(negedge clk); ext_set(0, 0, 32'h0, 32'h0); #1;
    @(negedge clk); #1;
    chk("e_rv",  32'(ext_rvalid), 32'h1);
    chk("e_err", 32'(ext_err),    32'h1);

    // Reset while an external read owns memory.
    @(negedge clk); ext_set(1, 0, 32'h40, 32'h0); #1;
    chk("x_gnt", 32'(ext_gnt), 32'h1);
    @(negedge clk); ext_set(0, 0, 32'h0, 32'h0); rst_n = 1'b0; #1;
    chk("x_mre", 32'(mem_rd_en), 32'h0);
    @(negedge clk); #1;
    chk("x_rv",    32'(ext_rvalid), 32'h0);
    chk("x_err",   32'(ext_err),    32'h0);
    chk("x_rdata", ext_rdata,       32'h0);
    chk("x_stall", 32'(cpu_stall),  32'h0);
    chk("x_gnt2",  32'(ext_gnt),    32'h0);
    chk("x_mre2",  32'(mem_rd_en),  32'h0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("x_rv2", 32'(ext_rvalid), 32'h0);
    chk("x_mem", mem[8'h10],      32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
